// File: rtl/movem_sequencer.sv
// -----------------------------------------------------------------------------
// movem_sequencer
//
// Register-list sequencer for MOVEM. It latches the 16-bit register mask from
// the extension word and presents one register per accepted transfer to the
// register-bank read/write multiplexers. It handshakes with the bus-cycle
// controller through VALID/READY.
//
// Ports
//   CLK          clock; all state updates on the rising edge
//   RESET        synchronous, active-high reset
//   START        load MASK/PREDEC and begin a sequence (honoured only in IDLE)
//   MASK         register list from the MOVEM extension word
//   PREDEC       1 = -(An) addressing: reversed mask bit order
//   READY        consumer accepts the current register this cycle
//   VALID        REG_SEL / REG_IS_ADDR / LAST are valid
//   REG_SEL      register number within the bank (mux select)
//   REG_IS_ADDR  0 = data bank D0-D7, 1 = address bank A0-A7
//   LAST         current register is the final one in the list
//   BUSY         sequence in progress
//   DONE         one-cycle pulse: sequence complete
//   COUNT        transfers remaining including the current one
//
// Build option
//   MOVEM_SEQ_COUNT_EN  when defined, COUNT is the popcount of the pending
//                       mask while running; otherwise COUNT is tied to 0.
// -----------------------------------------------------------------------------
module movem_sequencer #(
    parameter int MASK_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [MASK_W-1:0] MASK,
    input  logic              PREDEC,
    input  logic              READY,
    output logic              VALID,
    output logic [2:0]        REG_SEL,
    output logic              REG_IS_ADDR,
    output logic              LAST,
    output logic              BUSY,
    output logic              DONE,
    output logic [4:0]        COUNT
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [MASK_W-1:0] pend;
    logic              mode;
    logic              done_r;
    logic [3:0]        cur_bit;
    logic [3:0]        reg_idx;
    logic              one_left;
    logic              accept;

    // Lowest-index pending bit; iterate downward so the lowest set bit wins.
    always_comb begin
        cur_bit = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (pend[i]) cur_bit = 4'(i);
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign one_left = (pend != '0) && ((pend & (pend - 1'b1)) == '0);
    assign reg_idx  = mode ? (4'd15 - cur_bit) : cur_bit;
    assign accept   = (state == S_RUN) && READY;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (START && (MASK != '0)) state_nxt = S_RUN;
            S_RUN:  if (READY && one_left)     state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pending mask, ordering mode and DONE pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend   <= '0;
            mode   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if ((state == S_IDLE) && START) begin
                pend   <= MASK;
                mode   <= PREDEC;
                done_r <= (MASK == '0);
            end else if (accept) begin
                // x & (x-1) clears the lowest set bit, i.e. the current one.
                pend   <= pend & (pend - 1'b1);
                done_r <= one_left;
            end
        end
    end

`ifdef MOVEM_SEQ_COUNT_EN
    logic [4:0] pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < MASK_W; i++) pop = pop + 5'(pend[i]);
    end
`endif

    // Output logic: everything except DONE is forced to 0 outside RUN.
    always_comb begin
        VALID       = (state == S_RUN);
        BUSY        = (state == S_RUN);
        REG_SEL     = VALID ? reg_idx[2:0] : 3'd0;
        REG_IS_ADDR = VALID ? reg_idx[3]   : 1'b0;
        LAST        = VALID ? one_left     : 1'b0;
        DONE        = done_r;
`ifdef MOVEM_SEQ_COUNT_EN
        COUNT       = VALID ? pop : 5'd0;
`else
        COUNT       = 5'd0;
`endif
    end

endmodule

// File: tb/tb_movem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_movem_sequencer
//
// Bench for movem_sequencer. A reference model holds the remaining register
// sequence as a queue of register numbers (0-7 = D0-D7, 8-15 = A0-A7) built
// directly from the mask and ordering mode; the head of the queue is the
// register that must be presented. Directed steps are followed by randomized
// sequences with random READY stalls, stray STARTs and occasional resets.
// -----------------------------------------------------------------------------
module tb_movem_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [15:0] MASK;
    logic        PREDEC;
    logic        READY;
    logic        VALID;
    logic [2:0]  REG_SEL;
    logic        REG_IS_ADDR;
    logic        LAST;
    logic        BUSY;
    logic        DONE;
    logic [4:0]  COUNT;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int q[$];
    bit exp_done;

    movem_sequencer #(.MASK_W(16)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .MASK        (MASK),
        .PREDEC      (PREDEC),
        .READY       (READY),
        .VALID       (VALID),
        .REG_SEL     (REG_SEL),
        .REG_IS_ADDR (REG_IS_ADDR),
        .LAST        (LAST),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .COUNT       (COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register order for a list: ascending bit index, reversed register
    // numbering in predecrement mode.
    task automatic load_list(input logic [15:0] m, input logic pd);
        q = {};
        for (int i = 0; i < 16; i++) begin
            if (m[i]) q.push_back(pd ? (15 - i) : i);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, then
    // advance the model across the rising edge.
    task automatic step(input logic rst_i, input logic st_i, input logic [15:0] m_i,
                        input logic pd_i, input logic rdy_i);
        int  head;
        bit  ev;
        int  ecount;
        @(negedge CLK);
        ev   = (q.size() != 0);
        head = ev ? q[0] : 0;
`ifdef MOVEM_SEQ_COUNT_EN
        ecount = q.size();
`else
        ecount = 0;
`endif
        chk("valid",   32'(VALID),       32'(ev));
        chk("busy",    32'(BUSY),        32'(ev));
        chk("reg_sel", 32'(REG_SEL),     32'(head % 8));
        chk("is_addr", 32'(REG_IS_ADDR), 32'(head / 8));
        chk("last",    32'(LAST),        32'(q.size() == 1));
        chk("done",    32'(DONE),        32'(exp_done));
        chk("count",   32'(COUNT),       32'(ecount));

        RESET  = rst_i;
        START  = st_i;
        MASK   = m_i;
        PREDEC = pd_i;
        READY  = rdy_i;

        if (rst_i) begin
            q        = {};
            exp_done = 1'b0;
        end else if (q.size() != 0) begin
            exp_done = 1'b0;
            if (rdy_i) begin
                void'(q.pop_front());
                if (q.size() == 0) exp_done = 1'b1;
            end
        end else begin
            exp_done = 1'b0;
            if (st_i) begin
                load_list(m_i, pd_i);
                if (q.size() == 0) exp_done = 1'b1;
            end
        end
        @(posedge CLK);
    endtask

    initial begin
        RESET  = 1'b1;
        START  = 1'b0;
        MASK   = '0;
        PREDEC = 1'b0;
        READY  = 1'b0;
        q        = {};
        exp_done = 1'b0;
        repeat (2) @(posedge CLK);

        // Reset state, then release
        step(1, 0, 16'h0000, 0, 0);
        step(0, 0, 16'h0000, 0, 0);

        // D0, D1 with READY high
        step(0, 1, 16'h0003, 0, 1);
        repeat (3) step(0, 0, 16'h0000, 0, 1);

        // Predecrement: A7 then D0
        step(0, 1, 16'h8001, 1, 1);
        repeat (3) step(0, 0, 16'h0000, 0, 1);

        // Empty list: DONE only
        step(0, 1, 16'h0000, 0, 1);
        repeat (2) step(0, 0, 16'h0000, 0, 1);

        // A0..A3 with a three-cycle stall after the first accept
        step(0, 1, 16'h0F00, 0, 1);
        step(0, 0, 16'h0000, 0, 1);
        repeat (3) step(0, 0, 16'h0000, 0, 0);
        repeat (4) step(0, 0, 16'h0000, 0, 1);

        // START with a full mask while running is ignored
        step(0, 1, 16'h00F0, 0, 1);
        step(0, 1, 16'hFFFF, 1, 1);
        step(0, 1, 16'hFFFF, 0, 0);
        repeat (4) step(0, 0, 16'h0000, 0, 1);

        // START in the DONE cycle is accepted
        step(0, 1, 16'h0001, 0, 1);
        step(0, 0, 16'h0000, 0, 1);
        step(0, 1, 16'h4002, 0, 1);
        repeat (3) step(0, 0, 16'h0000, 0, 1);

        // Reset after the second accept of a full list, then a fresh start
        step(0, 1, 16'hFFFF, 0, 1);
        repeat (2) step(0, 0, 16'h0000, 0, 1);
        step(1, 0, 16'h0000, 0, 1);
        step(0, 0, 16'h0000, 0, 0);
        step(0, 1, 16'h0005, 1, 1);
        repeat (3) step(0, 0, 16'h0000, 0, 1);

        // Randomized sequences
        for (int s = 0; s < 60; s++) begin
            logic [15:0] m;
            logic        pd;
            m  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) m = '0;
            pd = 1'($urandom);
            step(0, 1, m, pd, 1'($urandom));
            for (int k = 0; k < 80 && q.size() != 0; k++) begin
                step(($urandom_range(0, 60) == 0), 1'($urandom), 16'($urandom),
                     1'($urandom), ($urandom_range(0, 3) != 0));
            end
            repeat ($urandom_range(0, 2)) step(0, 0, 16'h0000, 0, 1);
        end
        step(0, 0, 16'h0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
